// File: rtl/address_offset_loader.sv
// rtl/address_offset_loader.sv - streams PO/DO offset table into the Address Module write port
// Pipeline writes always win the port; loader beats fill the remaining cycles.
module address_offset_loader #(
    parameter int WORD_WIDTH       = 36,
    parameter int WRITE_ADDR_WIDTH = 12,
    parameter int PO_ADDR_BASE     = 0,
    parameter int PO_ENTRY_COUNT   = 4,
    parameter int DO_ADDR          = 4,
    parameter int NULL_WRITE_ADDR  = 0,
    parameter int INDEX_WIDTH      = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load_start,
    input  logic                        load_abort,
    input  logic                        src_valid,
    output logic                        src_ready,
    input  logic [WORD_WIDTH-1:0]       src_data,
    input  logic                        pipe_write_valid,
    input  logic [WRITE_ADDR_WIDTH-1:0] pipe_write_addr,
    input  logic [WORD_WIDTH-1:0]       pipe_write_data,
    output logic [WRITE_ADDR_WIDTH-1:0] write_addr,
    output logic [WORD_WIDTH-1:0]       write_data,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0]      LAST_IDX  = INDEX_WIDTH'(PO_ENTRY_COUNT);
    localparam logic [WRITE_ADDR_WIDTH-1:0] NULL_ADDR = WRITE_ADDR_WIDTH'(NULL_WRITE_ADDR);

    state_t                        state_q;
    logic [INDEX_WIDTH-1:0]        index_q;
    logic [WRITE_ADDR_WIDTH-1:0]   write_addr_q;
    logic [WRITE_ADDR_WIDTH-1:0]   write_addr_d;
    logic [WORD_WIDTH-1:0]         write_data_q;
    logic [WORD_WIDTH-1:0]         write_data_d;
    logic                          busy_q;
    logic                          done_q;
    logic                          accept;

    assign src_ready  = (state_q == ST_LOAD) & ~pipe_write_valid & ~load_abort;
    assign accept     = src_valid & src_ready;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        write_addr_d = NULL_ADDR;
        write_data_d = '0;
        if (pipe_write_valid) begin
            write_addr_d = pipe_write_addr;
            write_data_d = pipe_write_data;
        end else if (accept) begin
            write_data_d = src_data;
            if (index_q == LAST_IDX) begin
                write_addr_d = WRITE_ADDR_WIDTH'(DO_ADDR);
            end else begin
                write_addr_d = WRITE_ADDR_WIDTH'(PO_ADDR_BASE) + WRITE_ADDR_WIDTH'(index_q);
            end
        end
    end

    // busy/done are registered from the state so they line up with the write they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            write_addr_q <= NULL_ADDR;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= (state_q == ST_LOAD);
            done_q       <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q <= ST_LOAD;
                        index_q <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_abort) begin
                        state_q <= ST_IDLE;
                    end else if (accept) begin
                        if (index_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end else begin
                            index_q <= index_q + INDEX_WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
